// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay-line ramp controller.
package delay_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    CAL_SETTLE,
    CAL_SAMPLE,
    CAL_RETURN
  } ctrl_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int unsigned chan_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Saturate a requested tap to the last tap of the line.
  function automatic int unsigned clamp_tap(int unsigned tap, int unsigned max_tap);
    return (tap > max_tap) ? max_tap : tap;
  endfunction

endpackage

// File: rtl/delay_settle_timer.sv
// Settle-window counter: counts 0..SettleCycles-1 while enabled, ticks on wrap.
module delay_settle_timer #(
  parameter int SettleCycles = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SettleCycles - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tick_o = en_i && (count_q == CntMax);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tick_o ? '0 : count_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/delay_ramp_ctrl.sv
// Multi-channel delay-line controller: glitch-free single-tap ramping and
// calibration sweep searching for the first 0->1 phase-detector transition.
module delay_ramp_ctrl
  import delay_ctrl_pkg::*;
#(
  parameter int NumChannels  = 2,
  parameter int NumSteps     = 16,
  parameter int SettleCycles = 4,
  parameter int ResetDelay   = 0,
  localparam int DelayW      = $clog2(NumSteps),
  localparam int ChanW       = chan_w(NumChannels)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [ChanW-1:0]              req_chan_i,
  input  logic [DelayW-1:0]             req_delay_i,
  input  logic                          req_cal_i,
  input  logic [NumChannels-1:0]        phase_i,
  output logic [NumChannels*DelayW-1:0] delay_o,
  output logic [NumChannels-1:0]        busy_o,
  output logic                          cal_done_o,
  output logic                          cal_found_o,
  output logic [DelayW-1:0]             cal_tap_o
);

  ctrl_state_e       state_q, state_d;
  logic [ChanW-1:0]  chan_q, chan_d;
  logic [DelayW-1:0] target_q, target_d;
  logic              cal_q, cal_d;
  logic              prev_q, prev_d;
  logic              cal_done_q, cal_done_d;
  logic              cal_found_q, cal_found_d;
  logic [DelayW-1:0] cal_tap_q, cal_tap_d;
  logic [DelayW-1:0] delay_q [NumChannels];

  logic              accept, chan_ok, tick, timer_clr, timer_en;
  logic              code_we;
  logic [DelayW-1:0] code_wd, cur_code, step_code, req_tgt;

  assign req_ready_o = (state_q == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign chan_ok     = (32'(req_chan_i) < NumChannels);
  assign cur_code    = delay_q[chan_q];
  assign step_code   = (cur_code > target_q) ? cur_code - 1'b1 : cur_code + 1'b1;
  assign timer_clr   = accept || (state_q == CAL_SAMPLE);
  assign timer_en    = (state_q == RAMP) || (state_q == CAL_SETTLE) || (state_q == CAL_RETURN);

  delay_settle_timer #(
    .SettleCycles(SettleCycles)
  ) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (timer_clr),
    .en_i  (timer_en),
    .tick_o(tick)
  );

  // Next-state logic: request capture, ramp stepping and sweep decisions.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    target_d    = target_q;
    cal_d       = cal_q;
    prev_d      = prev_q;
    code_we     = 1'b0;
    code_wd     = cur_code;
    cal_done_d  = 1'b0;
    cal_found_d = cal_found_q;
    cal_tap_d   = cal_tap_q;
    req_tgt     = req_cal_i ? '0 : DelayW'(clamp_tap(32'(req_delay_i), NumSteps - 1));
    unique case (state_q)
      IDLE: begin
        // Out-of-range channels are consumed without any effect.
        if (accept && chan_ok) begin
          chan_d   = req_chan_i;
          target_d = req_tgt;
          cal_d    = req_cal_i;
          if (req_tgt != delay_q[req_chan_i]) state_d = RAMP;
          else if (req_cal_i)                 state_d = CAL_SETTLE;
        end
      end
      RAMP: begin
        if (tick) begin
          code_we = 1'b1;
          code_wd = step_code;
          if (step_code == target_q) state_d = cal_q ? CAL_SETTLE : IDLE;
        end
      end
      CAL_SETTLE: begin
        if (tick) state_d = CAL_SAMPLE;
      end
      CAL_SAMPLE: begin
        if ((cur_code != '0) && !prev_q && phase_i[chan_q]) begin
          state_d     = IDLE;
          cal_done_d  = 1'b1;
          cal_found_d = 1'b1;
          cal_tap_d   = cur_code;
        end else begin
          prev_d = phase_i[chan_q];
          if (32'(cur_code) < NumSteps - 1) begin
            code_we = 1'b1;
            code_wd = cur_code + 1'b1;
            state_d = CAL_SETTLE;
          end else begin
            state_d = CAL_RETURN;
          end
        end
      end
      CAL_RETURN: begin
        // target_q is 0 throughout calibration, so step_code walks down.
        if (tick) begin
          code_we = 1'b1;
          code_wd = step_code;
          if (step_code == '0) begin
            state_d     = IDLE;
            cal_done_d  = 1'b1;
            cal_found_d = 1'b0;
            cal_tap_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and per-channel tap registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      chan_q      <= '0;
      target_q    <= '0;
      cal_q       <= 1'b0;
      prev_q      <= 1'b0;
      cal_done_q  <= 1'b0;
      cal_found_q <= 1'b0;
      cal_tap_q   <= '0;
      // NOTE: the tap array is reset because the delay lines must come up at a known code.
      for (int c = 0; c < NumChannels; c++) delay_q[c] <= DelayW'(ResetDelay);
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      target_q    <= target_d;
      cal_q       <= cal_d;
      prev_q      <= prev_d;
      cal_done_q  <= cal_done_d;
      cal_found_q <= cal_found_d;
      cal_tap_q   <= cal_tap_d;
      if (code_we) delay_q[chan_q] <= code_wd;
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    assign delay_o[c*DelayW +: DelayW] = delay_q[c];
    assign busy_o[c] = (state_q != IDLE) && (chan_q == ChanW'(c));
  end

  assign cal_done_o  = cal_done_q;
  assign cal_found_o = cal_found_q;
  assign cal_tap_o   = cal_tap_q;

endmodule
